// File: rtl/bldc_pkg.sv
// bldc_pkg: shared types and helpers for the hall commutation sequencer.
//   HALL_W             width of the hall sensor bus {HA,HB,HC}
//   state_t            sequencer FSM states (IDLE, RUN, FAULT)
//   GATE_STEP0..5      gate enables {AH,AL,BH,BL,CH,CL} for each commutation step
//   decode_hall()      hall code -> {valid, sector}; 000 and 111 are invalid
//   sectors_adjacent() true when two sectors differ by one modulo 6
//   step_for()         sector plus direction -> commutation step
//   gate_for()         commutation step -> gate pattern
package bldc_pkg;

  localparam int HALL_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FAULT
  } state_t;

  localparam logic [5:0] GATE_STEP0 = 6'b100100;
  localparam logic [5:0] GATE_STEP1 = 6'b100001;
  localparam logic [5:0] GATE_STEP2 = 6'b001001;
  localparam logic [5:0] GATE_STEP3 = 6'b011000;
  localparam logic [5:0] GATE_STEP4 = 6'b010010;
  localparam logic [5:0] GATE_STEP5 = 6'b000110;

  typedef struct packed {
    logic       valid;
    logic [2:0] sector;
  } hall_sector_t;

  function automatic hall_sector_t decode_hall(input logic [HALL_W-1:0] hall);
    hall_sector_t result;
    result.valid  = 1'b1;
    result.sector = 3'd0;
    case (hall)
      3'b101:  result.sector = 3'd0;
      3'b100:  result.sector = 3'd1;
      3'b110:  result.sector = 3'd2;
      3'b010:  result.sector = 3'd3;
      3'b011:  result.sector = 3'd4;
      3'b001:  result.sector = 3'd5;
      default: result.valid  = 1'b0;
    endcase
    return result;
  endfunction

  function automatic logic [2:0] next_sector(input logic [2:0] sector);
    return (sector >= 3'd5) ? 3'd0 : sector + 3'd1;
  endfunction

  function automatic logic sectors_adjacent(input logic [2:0] a, input logic [2:0] b);
    return (b == next_sector(a)) || (a == next_sector(b));
  endfunction

  // Reverse rotation is the forward table shifted by half a turn.
  function automatic logic [2:0] step_for(input logic [2:0] sector, input logic dir);
    logic [2:0] step;
    if (!dir) step = sector;
    else      step = (sector >= 3'd3) ? sector - 3'd3 : sector + 3'd3;
    return step;
  endfunction

  function automatic logic [5:0] gate_for(input logic [2:0] step);
    logic [5:0] gate;
    case (step)
      3'd0:    gate = GATE_STEP0;
      3'd1:    gate = GATE_STEP1;
      3'd2:    gate = GATE_STEP2;
      3'd3:    gate = GATE_STEP3;
      3'd4:    gate = GATE_STEP4;
      3'd5:    gate = GATE_STEP5;
      default: gate = 6'b000000;
    endcase
    return gate;
  endfunction

endpackage

// File: rtl/hall_input_filter.sv
// hall_input_filter: two-flop synchroniser plus run-length debounce for the
// hall sensor bus.
//   clk      system clock, rising edge
//   reset    asynchronous, active-high
//   hall     raw asynchronous hall sensors {HA,HB,HC}
//   code     debounced hall code, 000 out of reset
//   changed  one-cycle strobe, high on the edge code takes a new value
module hall_input_filter
  import bldc_pkg::*;
#(
  parameter int FILT_LEN = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [HALL_W-1:0] hall,
  output logic [HALL_W-1:0] code,
  output logic              changed
);

  localparam logic [3:0] FILT_TARGET = 4'(FILT_LEN);

  logic [HALL_W-1:0] sync1;
  logic [HALL_W-1:0] sync2;
  logic [HALL_W-1:0] candidate;
  logic [3:0]        run_len;
  logic [3:0]        run_len_next;

  // Length of the current run of identical synchronised samples, counting
  // the sample present at this edge. Saturates once the target is reached.
  always_comb begin
    run_len_next = run_len;
    if (sync2 != candidate)         run_len_next = 4'd1;
    else if (run_len < FILT_TARGET) run_len_next = run_len + 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1     <= '0;
      sync2     <= '0;
      candidate <= '0;
      run_len   <= '0;
      code      <= '0;
      changed   <= 1'b0;
    end else begin
      sync1     <= hall;
      sync2     <= sync1;
      candidate <= sync2;
      run_len   <= run_len_next;
      changed   <= 1'b0;
      if (run_len_next >= FILT_TARGET && sync2 != code) begin
        code    <= sync2;
        changed <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/hall_commutation_sequencer.sv
// hall_commutation_sequencer: six-step BLDC commutation from debounced hall
// sensors, with sector-period measurement and latched invalid/stall faults.
//   i_clk            system clock, rising edge
//   i_reset          asynchronous, active-high
//   i_enable         run request; low returns to IDLE and clears faults
//   i_dir            0 forward, 1 reverse
//   i_hall           raw hall sensors {HA,HB,HC}
//   o_gate           gate enables {AH,AL,BH,BL,CH,CL}
//   o_step           current commutation step 0..5
//   o_period         cycles between the last two accepted hall changes
//   o_period_valid   one-cycle pulse when o_period updates
//   o_fault_invalid  sticky invalid-code / sector-skip fault
//   o_fault_stall    sticky stall fault
//   o_running        high while in RUN
module hall_commutation_sequencer
  import bldc_pkg::*;
#(
  parameter int CNT_W    = 24,
  parameter int FILT_LEN = 4,
  parameter int TIMEOUT  = 10_000_000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_dir,
  input  logic [HALL_W-1:0] i_hall,
  output logic [5:0]        o_gate,
  output logic [2:0]        o_step,
  output logic [CNT_W-1:0]  o_period,
  output logic              o_period_valid,
  output logic              o_fault_invalid,
  output logic              o_fault_stall,
  output logic              o_running
);

  localparam logic [CNT_W-1:0] TIMEOUT_COUNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] COUNT_MAX     = '1;

  logic [HALL_W-1:0] code;
  logic              changed;
  hall_sector_t      decoded;
  logic [2:0]        run_step;
  logic              bad_code;
  logic              stalled;

  state_t            state;
  logic [CNT_W-1:0]  counter;
  logic [2:0]        last_sector;
  logic              measuring;

  hall_input_filter #(
    .FILT_LEN(FILT_LEN)
  ) u_filter (
    .clk    (i_clk),
    .reset  (i_reset),
    .hall   (i_hall),
    .code   (code),
    .changed(changed)
  );

  // A change is only legal to a neighbouring sector; last_sector holds the
  // sector in force before the current change strobe.
  always_comb begin
    decoded  = decode_hall(code);
    run_step = step_for(decoded.sector, i_dir);
    bad_code = !decoded.valid ||
               (changed && !sectors_adjacent(last_sector, decoded.sector));
    stalled  = (counter == TIMEOUT_COUNT);
  end

  // measuring stays low until the first accepted change after entering RUN,
  // so the partial first sector never produces a period.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state           <= IDLE;
      counter         <= '0;
      last_sector     <= '0;
      measuring       <= 1'b0;
      o_gate          <= '0;
      o_step          <= '0;
      o_period        <= '0;
      o_period_valid  <= 1'b0;
      o_fault_invalid <= 1'b0;
      o_fault_stall   <= 1'b0;
      o_running       <= 1'b0;
    end else begin
      o_period_valid <= 1'b0;
      case (state)
        IDLE: begin
          counter         <= '0;
          o_gate          <= '0;
          o_running       <= 1'b0;
          o_fault_invalid <= 1'b0;
          o_fault_stall   <= 1'b0;
          if (i_enable && decoded.valid) begin
            state       <= RUN;
            o_running   <= 1'b1;
            o_step      <= run_step;
            o_gate      <= gate_for(run_step);
            last_sector <= decoded.sector;
            measuring   <= 1'b0;
          end
        end

        RUN: begin
          if (!i_enable) begin
            state     <= IDLE;
            o_running <= 1'b0;
            o_gate    <= '0;
            counter   <= '0;
          end else if (bad_code || stalled) begin
            state           <= FAULT;
            o_running       <= 1'b0;
            o_gate          <= '0;
            o_fault_invalid <= bad_code;
            o_fault_stall   <= stalled;
          end else begin
            o_step <= run_step;
            o_gate <= gate_for(run_step);
            if (changed) begin
              last_sector <= decoded.sector;
              counter     <= '0;
              measuring   <= 1'b1;
              if (measuring) begin
                o_period       <= (counter == COUNT_MAX) ? counter : counter + CNT_W'(1);
                o_period_valid <= 1'b1;
              end
            end else if (counter != COUNT_MAX) begin
              counter <= counter + CNT_W'(1);
            end
          end
        end

        FAULT: begin
          o_gate    <= '0;
          o_running <= 1'b0;
          if (!i_enable) begin
            state           <= IDLE;
            counter         <= '0;
            o_fault_invalid <= 1'b0;
            o_fault_stall   <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
